// File: rtl/sound_pkg.sv
// Shared definitions for the sound path: silence divider, volume limits and
// the sequencer state encoding.
package sound_pkg;

    // A divider of 1 tells the note generator to stay silent (rest).
    localparam logic [21:0] SILENCE_DIV = 22'd1;

    localparam logic [2:0] VOL_MIN       = 3'd0;
    localparam logic [2:0] VOL_MAX       = 3'd5;
    // Downstream subtracts 3 from the volume when attenuating the left channel.
    localparam logic [2:0] LOWER_MIN_VOL = 3'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/beat_timer.sv
// Beat counter for the melody sequencer.
//   clk, rst       : clock, asynchronous active-high reset
//   run            : advance the counter this cycle (counter holds otherwise)
//   clear          : force the counter back to 0 (wins over run)
//   note_on_window : counter is inside the audible part of the beat
//   beat_end       : counter sits on its terminal value (BEAT_DIV-1); the
//                    owner decides whether this cycle really ends the beat
module beat_timer #(
    parameter int BEAT_DIV   = 25_000_000,
    parameter int GAP_CYCLES = 2_500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic note_on_window,
    output logic beat_end
);

    localparam int CNT_W = $clog2(BEAT_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEAT_DIV - 1);
    localparam logic [CNT_W-1:0] NOTE_END = CNT_W'(BEAT_DIV - GAP_CYCLES);

    logic [CNT_W-1:0] cnt_reg;

    assign beat_end       = (cnt_reg == CNT_LAST);
    assign note_on_window = (cnt_reg < NOTE_END);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (clear) begin
            cnt_reg <= '0;
        end else if (run) begin
            cnt_reg <= beat_end ? '0 : cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/melody_sequencer.sv
// Melody sequencer: steps an external combinational note ROM at a fixed beat
// rate, silences the tail of every beat, and drives the two-channel note
// generator plus volume / left-channel attenuation.
//   play/pause/stop        : one-cycle transport pulses (stop > pause > play)
//   vol_up/vol_down        : one-cycle volume pulses, saturating 0..5
//   loop_en                : restart the song after the last note
//   rom_addr -> rom_div_l/rom_div_r/rom_last : note ROM lookup
//   note_div_left/right    : registered dividers to the note generator
//   volume_L_ch            : registered volume level
//   ch_L_need_to_be_lowered: registered left attenuation request
//   playing                : registered, high while in PLAY
//   done                   : one-cycle pulse at song end when not looping
module melody_sequencer
    import sound_pkg::*;
#(
    parameter int BEAT_DIV    = 25_000_000,
    parameter int GAP_CYCLES  = 2_500_000,
    parameter int ADDR_W      = 6,
    parameter int VOL_DEFAULT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              play,
    input  logic              pause,
    input  logic              stop,
    input  logic              vol_up,
    input  logic              vol_down,
    input  logic              loop_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [21:0]       rom_div_l,
    input  logic [21:0]       rom_div_r,
    input  logic              rom_last,
    output logic [21:0]       note_div_left,
    output logic [21:0]       note_div_right,
    output logic [2:0]        volume_L_ch,
    output logic              ch_L_need_to_be_lowered,
    output logic              playing,
    output logic              done
);

    seq_state_t        state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [2:0]        vol_reg, vol_next;
    logic              done_next;
    logic              run, clear;
    logic              note_on_window, beat_end;
    logic              note_on;

    beat_timer #(
        .BEAT_DIV   (BEAT_DIV),
        .GAP_CYCLES (GAP_CYCLES)
    ) u_beat_timer (
        .clk            (clk),
        .rst            (rst),
        .run            (run),
        .clear          (clear),
        .note_on_window (note_on_window),
        .beat_end       (beat_end)
    );

    assign note_on  = (state_reg == PLAY) && note_on_window;
    assign rom_addr = addr_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        run        = 1'b0;
        clear      = 1'b0;
        done_next  = 1'b0;
        if (stop) begin
            state_next = IDLE;
            addr_next  = '0;
            clear      = 1'b1;
        end else if (pause && (state_reg == PLAY)) begin
            // The pause cycle itself is still a played cycle, so the counter
            // moves on; on the terminal count it waits instead, so that the
            // address advance happens after resume and no beat is lost.
            state_next = PAUSE;
            run        = !beat_end;
        end else if (play && (state_reg == IDLE)) begin
            state_next = PLAY;
            addr_next  = '0;
            clear      = 1'b1;
        end else if (play && (state_reg == PAUSE)) begin
            state_next = PLAY;
        end else if (state_reg == PLAY) begin
            run = 1'b1;
            if (beat_end) begin
                if (rom_last) begin
                    addr_next = '0;
                    if (!loop_en) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end else begin
                    addr_next = addr_reg + 1'b1;
                end
            end
        end
    end

    always_comb begin
        vol_next = vol_reg;
        if (vol_up && !vol_down && (vol_reg < VOL_MAX)) begin
            vol_next = vol_reg + 3'd1;
        end else if (vol_down && !vol_up && (vol_reg > VOL_MIN)) begin
            vol_next = vol_reg - 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vol_reg                 <= 3'(VOL_DEFAULT);
            note_div_left           <= SILENCE_DIV;
            note_div_right          <= SILENCE_DIV;
            ch_L_need_to_be_lowered <= 1'b0;
            playing                 <= 1'b0;
            done                    <= 1'b0;
        end else begin
            vol_reg                 <= vol_next;
            note_div_left           <= note_on ? rom_div_l : SILENCE_DIV;
            note_div_right          <= note_on ? rom_div_r : SILENCE_DIV;
            // Only lower when the right channel sounds and volume-3 is safe.
            ch_L_need_to_be_lowered <= note_on && (rom_div_r != SILENCE_DIV)
                                       && (vol_reg >= LOWER_MIN_VOL);
            playing                 <= (state_next == PLAY);
            done                    <= done_next;
        end
    end

    assign volume_L_ch = vol_reg;

endmodule

// File: tb/tb_melody_sequencer.sv
module tb_melody_sequencer;

    localparam int BD  = 8;
    localparam int GAP = 2;
    localparam int AW  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          play = 1'b0, pause = 1'b0, stop = 1'b0;
    logic          vol_up = 1'b0, vol_down = 1'b0, loop_en = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [21:0]   rom_div_l, rom_div_r;
    logic          rom_last;
    logic [21:0]   note_div_left, note_div_right;
    logic [2:0]    volume_L_ch;
    logic          ch_L_need_to_be_lowered, playing, done;

    logic [21:0]   rom_l [4];
    logic [21:0]   rom_r [4];
    int            last_idx = 3;

    assign rom_div_l = rom_l[rom_addr];
    assign rom_div_r = rom_r[rom_addr];
    assign rom_last  = (int'(rom_addr) == last_idx);

    melody_sequencer #(
        .BEAT_DIV    (BD),
        .GAP_CYCLES  (GAP),
        .ADDR_W      (AW),
        .VOL_DEFAULT (3)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .play                    (play),
        .pause                   (pause),
        .stop                    (stop),
        .vol_up                  (vol_up),
        .vol_down                (vol_down),
        .loop_en                 (loop_en),
        .rom_addr                (rom_addr),
        .rom_div_l               (rom_div_l),
        .rom_div_r               (rom_div_r),
        .rom_last                (rom_last),
        .note_div_left           (note_div_left),
        .note_div_right          (note_div_right),
        .volume_L_ch             (volume_L_ch),
        .ch_L_need_to_be_lowered (ch_L_need_to_be_lowered),
        .playing                 (playing),
        .done                    (done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: transport state 0 idle / 1 play / 2 pause, beat position,
    // song position, volume, and the outputs expected after the next edge.
    int          m_state, m_cnt, m_addr, m_vol;
    logic [21:0] e_l, e_r;
    int          e_vol;
    bit          e_low, e_play, e_done;

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_addr = 0; m_vol = 3;
        e_l = 22'd1; e_r = 22'd1; e_vol = 3;
        e_low = 0; e_play = 0; e_done = 0;
    endtask

    task automatic model_step(input bit p, input bit pa, input bit s,
                              input bit u, input bit d);
        bit sounding;
        sounding = (m_state == 1) && (m_cnt < BD - GAP);
        e_l   = sounding ? rom_l[m_addr] : 22'd1;
        e_r   = sounding ? rom_r[m_addr] : 22'd1;
        e_low = sounding && (rom_r[m_addr] != 22'd1) && (m_vol >= 3);
        e_done = 0;
        if (s) begin
            m_state = 0; m_cnt = 0; m_addr = 0;
        end else if (pa && m_state == 1) begin
            m_state = 2;
            if (m_cnt != BD - 1) m_cnt = m_cnt + 1;
        end else if (p && m_state == 0) begin
            m_state = 1; m_cnt = 0; m_addr = 0;
        end else if (p && m_state == 2) begin
            m_state = 1;
        end else if (m_state == 1) begin
            if (m_cnt == BD - 1) begin
                m_cnt = 0;
                if (m_addr == last_idx) begin
                    m_addr = 0;
                    if (!loop_en) begin
                        m_state = 0;
                        e_done  = 1;
                    end
                end else begin
                    m_addr = (m_addr + 1) % 4;
                end
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
        if (u && !d && m_vol < 5) m_vol = m_vol + 1;
        if (d && !u && m_vol > 0) m_vol = m_vol - 1;
        e_vol  = m_vol;
        e_play = (m_state == 1);
    endtask

    // One clock: drive pulses at the falling edge, step the model, sample
    // one time unit after the rising edge, then drop the pulses.
    task automatic cycle(input bit p, input bit pa, input bit s,
                         input bit u, input bit d);
        @(negedge clk);
        play = p; pause = pa; stop = s; vol_up = u; vol_down = d;
        model_step(p, pa, s, u, d);
        @(posedge clk);
        #1;
        play = 0; pause = 0; stop = 0; vol_up = 0; vol_down = 0;
        cyc++;
        $display("cyc=%0d in(p=%0b pa=%0b s=%0b u=%0b d=%0b loop=%0b) addr=%0d L=%0d R=%0d vol=%0d low=%0b play=%0b done=%0b",
                 cyc, p, pa, s, u, d, loop_en, rom_addr, note_div_left,
                 note_div_right, volume_L_ch, ch_L_need_to_be_lowered,
                 playing, done);
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        checks++; if (note_div_left !== 22'd1) begin failures++; $display("FAIL reset_ndl got=%0d exp=1", note_div_left); end
        checks++; if (note_div_right !== 22'd1) begin failures++; $display("FAIL reset_ndr got=%0d exp=1", note_div_right); end
        checks++; if (volume_L_ch !== 3'd3) begin failures++; $display("FAIL reset_vol got=%0d exp=3", volume_L_ch); end
        checks++; if (rom_addr !== 2'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", rom_addr); end
        checks++; if ({ch_L_need_to_be_lowered, playing, done} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {ch_L_need_to_be_lowered, playing, done}); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_play_note();
        rom_l[0] = 22'd191571; rom_r[0] = 22'd1;
        loop_en = 1'b1;
        cycle(1, 0, 0, 0, 0);
        for (int k = 1; k <= 8; k++) begin
            cycle(0, 0, 0, 0, 0);
            checks++; if (note_div_left !== ((k <= 6) ? 22'd191571 : 22'd1)) begin failures++; $display("FAIL play_note_ndl k=%0d got=%0d exp=%0d", k, note_div_left, (k <= 6) ? 191571 : 1); end
            checks++; if (rom_addr !== ((k == 8) ? 2'd1 : 2'd0)) begin failures++; $display("FAIL play_note_addr k=%0d got=%0d exp=%0d", k, rom_addr, (k == 8) ? 1 : 0); end
            checks++; if (playing !== 1'b1) begin failures++; $display("FAIL play_note_playing k=%0d got=%b exp=1", k, playing); end
        end
    endtask

    // Continues from addr 1, cnt 0 with looping disabled.
    task automatic test_song_end();
        int done_cnt = 0;
        int done_at  = -1;
        loop_en = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            cycle(0, 0, 0, 0, 0);
            if (done === 1'b1) begin done_cnt++; done_at = k; end
            if (k == 23) begin
                checks++; if (rom_addr !== 2'd3) begin failures++; $display("FAIL song_end_lastaddr got=%0d exp=3", rom_addr); end
            end
        end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL song_end_done_count got=%0d exp=1", done_cnt); end
        checks++; if (done_at !== 24) begin failures++; $display("FAIL song_end_done_cycle got=%0d exp=24", done_at); end
        checks++; if (playing !== 1'b0) begin failures++; $display("FAIL song_end_playing got=%b exp=0", playing); end
        checks++; if (rom_addr !== 2'd0) begin failures++; $display("FAIL song_end_addr got=%0d exp=0", rom_addr); end
    endtask

    task automatic test_pause_resume();
        logic [21:0] n;
        n = 22'($urandom_range(2, 4194303));
        rom_l[0] = n; rom_r[0] = 22'd1;
        loop_en = 1'b1;
        cycle(0, 0, 1, 0, 0);
        cycle(1, 0, 0, 0, 0);
        repeat (3) cycle(0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        checks++; if (note_div_left !== n) begin failures++; $display("FAIL pause_edge_ndl got=%0d exp=%0d", note_div_left, n); end
        checks++; if (playing !== 1'b0) begin failures++; $display("FAIL pause_playing got=%b exp=0", playing); end
        for (int k = 0; k < 20; k++) begin
            cycle(0, 0, 0, 0, 0);
            checks++; if (note_div_left !== 22'd1 || note_div_right !== 22'd1) begin failures++; $display("FAIL paused_silent k=%0d got=%0d/%0d exp=1/1", k, note_div_left, note_div_right); end
        end
        cycle(1, 0, 0, 0, 0);
        checks++; if (playing !== 1'b1) begin failures++; $display("FAIL resume_playing got=%b exp=1", playing); end
        for (int k = 0; k < 4; k++) begin
            cycle(0, 0, 0, 0, 0);
            checks++; if (note_div_left !== ((k < 2) ? n : 22'd1)) begin failures++; $display("FAIL resume_ndl k=%0d got=%0d exp=%0d", k, note_div_left, (k < 2) ? n : 22'd1); end
        end
        checks++; if (rom_addr !== 2'd1) begin failures++; $display("FAIL resume_addr got=%0d exp=1", rom_addr); end
    endtask

    // All three transport pulses on the beat_end cycle of the last note.
    task automatic test_simultaneous();
        cycle(0, 0, 1, 0, 0);
        loop_en = 1'b0;
        cycle(1, 0, 0, 0, 0);
        repeat (31) cycle(0, 0, 0, 0, 0);
        cycle(1, 1, 1, 0, 0);
        checks++; if (playing !== 1'b0) begin failures++; $display("FAIL simul_playing got=%b exp=0", playing); end
        checks++; if (rom_addr !== 2'd0) begin failures++; $display("FAIL simul_addr got=%0d exp=0", rom_addr); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (done !== 1'b0) begin failures++; $display("FAIL simul_done k=%0d got=%b exp=0", k, done); end
            cycle(0, 0, 0, 0, 0);
        end
    endtask

    task automatic test_volume();
        for (int i = 1; i <= 4; i++) begin
            cycle(0, 0, 0, 1, 0);
            checks++; if (int'(volume_L_ch) !== ((3 + i > 5) ? 5 : 3 + i)) begin failures++; $display("FAIL vol_up i=%0d got=%0d exp=%0d", i, volume_L_ch, (3 + i > 5) ? 5 : 3 + i); end
        end
        for (int i = 1; i <= 6; i++) begin
            cycle(0, 0, 0, 0, 1);
            checks++; if (int'(volume_L_ch) !== ((5 - i < 0) ? 0 : 5 - i)) begin failures++; $display("FAIL vol_down i=%0d got=%0d exp=%0d", i, volume_L_ch, (5 - i < 0) ? 0 : 5 - i); end
        end
        cycle(0, 0, 0, 1, 1);
        checks++; if (volume_L_ch !== 3'd0) begin failures++; $display("FAIL vol_both_at0 got=%0d exp=0", volume_L_ch); end
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 1, 1);
        checks++; if (volume_L_ch !== 3'd2) begin failures++; $display("FAIL vol_both_at2 got=%0d exp=2", volume_L_ch); end
    endtask

    // Entered with volume 2.
    task automatic test_lowered();
        rom_l[0] = 22'($urandom_range(2, 4194303));
        rom_r[0] = 22'($urandom_range(2, 4194303));
        loop_en = 1'b1;
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        checks++; if (note_div_right !== rom_r[0]) begin failures++; $display("FAIL lowered_ndr got=%0d exp=%0d", note_div_right, rom_r[0]); end
        checks++; if (ch_L_need_to_be_lowered !== 1'b0) begin failures++; $display("FAIL lowered_vol2 got=%b exp=0", ch_L_need_to_be_lowered); end
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 1, 0);
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        checks++; if (ch_L_need_to_be_lowered !== 1'b1) begin failures++; $display("FAIL lowered_vol4 got=%b exp=1", ch_L_need_to_be_lowered); end
        cycle(0, 0, 1, 0, 0);
    endtask

    task automatic test_reset_mid_play();
        loop_en = 1'b1;
        cycle(1, 0, 0, 0, 0);
        repeat ($urandom_range(3, 20)) cycle(0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        checks++; if (note_div_left !== 22'd1 || note_div_right !== 22'd1) begin failures++; $display("FAIL midreset_ndiv got=%0d/%0d exp=1/1", note_div_left, note_div_right); end
        checks++; if (volume_L_ch !== 3'd3) begin failures++; $display("FAIL midreset_vol got=%0d exp=3", volume_L_ch); end
        checks++; if (rom_addr !== 2'd0) begin failures++; $display("FAIL midreset_addr got=%0d exp=0", rom_addr); end
        checks++; if ({ch_L_need_to_be_lowered, playing, done} !== 3'b000) begin failures++; $display("FAIL midreset_flags got=%b exp=000", {ch_L_need_to_be_lowered, playing, done}); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++) begin
            rom_l[i] = ($urandom_range(0, 3) == 0) ? 22'd1 : 22'($urandom_range(2, 4194303));
            rom_r[i] = ($urandom_range(0, 3) == 0) ? 22'd1 : 22'($urandom_range(2, 4194303));
        end
        last_idx = $urandom_range(0, 3);
        for (int k = 0; k < 700; k++) begin
            bit p, pa, s, u, d;
            if ($urandom_range(0, 63) == 0) loop_en = ~loop_en;
            p  = ($urandom_range(0, 9) == 0);
            pa = ($urandom_range(0, 19) == 0);
            s  = ($urandom_range(0, 59) == 0);
            u  = ($urandom_range(0, 11) == 0);
            d  = ($urandom_range(0, 11) == 0);
            cycle(p, pa, s, u, d);
            checks++; if (int'(rom_addr) !== m_addr) begin failures++; $display("FAIL rnd_addr k=%0d got=%0d exp=%0d", k, rom_addr, m_addr); end
            checks++; if (note_div_left !== e_l) begin failures++; $display("FAIL rnd_ndl k=%0d got=%0d exp=%0d", k, note_div_left, e_l); end
            checks++; if (note_div_right !== e_r) begin failures++; $display("FAIL rnd_ndr k=%0d got=%0d exp=%0d", k, note_div_right, e_r); end
            checks++; if (int'(volume_L_ch) !== e_vol) begin failures++; $display("FAIL rnd_vol k=%0d got=%0d exp=%0d", k, volume_L_ch, e_vol); end
            checks++; if (ch_L_need_to_be_lowered !== e_low) begin failures++; $display("FAIL rnd_low k=%0d got=%b exp=%b", k, ch_L_need_to_be_lowered, e_low); end
            checks++; if (playing !== e_play) begin failures++; $display("FAIL rnd_playing k=%0d got=%b exp=%b", k, playing, e_play); end
            checks++; if (done !== e_done) begin failures++; $display("FAIL rnd_done k=%0d got=%b exp=%b", k, done, e_done); end
        end
        last_idx = 3;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            rom_l[i] = 22'($urandom_range(2, 4194303));
            rom_r[i] = 22'd1;
        end
        model_reset();
        test_reset();
        test_play_note();
        test_song_end();
        test_pause_resume();
        test_simultaneous();
        test_volume();
        test_lowered();
        test_reset_mid_play();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
